insn_sequencer: RTL

- Multi-cycle control sequencer for the RV32I core. It replaces the two-phase, clock-gated instruction decoder with a single-clock FSM that produces enable strobes.
- Fetches over a single shared memory port, latches the instruction, and steps it through the EXEC, MEM and WB states.
- Resolves branches from the ALU compare flags and drives the datapath select lines.
- Adds wait-state handshaking, bus timeout trapping, illegal-code trapping and a retire counter.

---
 rtl/insn_sequencer.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/insn_sequencer.sv
// ----------------------------------------------------------------------------
// insn_sequencer
//   Multi-cycle control sequencer for the RV32I core. A single-clock FSM walks
//   each instruction through IDLE -> FETCH -> EXEC -> (MEM) -> WB and decodes
//   the datapath strobes and select lines combinationally from the state, the
//   latched instruction, the one-hot class code and the latched branch result.
//   Bus stalls longer than TIMEOUT cycles and illegal class codes or branch
//   conditions park the FSM in a sticky TRAP state until reset.
//
// Parameters
//   TIMEOUT : cycles mem_req may wait for mem_ready before trapping (0 = off)
//   RET_W   : width of the retired-instruction counter
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   mem_rdata, mem_ready  shared memory read data and completion handshake
//   code                  one-hot instruction class from the opcode decoder
//   EQ, LS, LU            ALU compare flags (equal, signed <, unsigned <)
//   ir                    latched instruction
//   mem_req, mem_we       memory request and store strobe
//   addr_sel              0 = PC drives the address, 1 = ALU result
//   pc_alu_sel            1 = PC is ALU operand A
//   sub_sra               ALU subtract / arithmetic shift select
//   pc_next_sel, pc_we    next-PC select (0 = PC+4, 1 = ALU) and PC strobe
//   rd_we                 register-file write strobe
//   trap, trap_cause      sticky fault flag and cause (01 illegal, 10 timeout)
//   retired               count of completed instructions (wraps)
// ----------------------------------------------------------------------------
module insn_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  input  logic [9:0]       code,
  input  logic             EQ,
  input  logic             LS,
  input  logic             LU,
  output logic [31:0]      ir,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             pc_alu_sel,
  output logic             sub_sra,
  output logic             pc_next_sel,
  output logic             pc_we,
  output logic             rd_we,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [RET_W-1:0] retired
);

  // Class bit positions inside code
  localparam int C_LUI    = 0;
  localparam int C_AUIPC  = 1;
  localparam int C_JAL    = 2;
  localparam int C_JALR   = 3;
  localparam int C_BRANCH = 4;
  localparam int C_LOAD   = 5;
  localparam int C_STORE  = 6;
  localparam int C_OP_IMM = 7;
  localparam int C_OP     = 8;
  localparam int C_SYSTEM = 9;

  // The wait counter only has to reach TIMEOUT-1: the cycle in which it holds
  // that value is the TIMEOUT-th waiting cycle.
  localparam bit TO_EN = (TIMEOUT > 32'sd0);
  localparam int CNT_W = (TIMEOUT > 32'sd1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 32'sd1) : {CNT_W{1'b0}};

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_TRAP  = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [31:0]       ir_r;
  logic              taken_r;
  logic              taken_s;
  logic              trap_r;
  logic [1:0]        cause_r;
  logic [1:0]        cause_s;
  logic [RET_W-1:0]  retired_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic              code_ok_s;
  logic [1:0]        br_s;
  logic              timeout_hit_s;

  // True when exactly one class bit is set
  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  // Branch condition from funct3: returns {legal, taken}
  function automatic logic [1:0] branch_eval(input logic [2:0] f3, input logic eq,
                                             input logic ls, input logic lu);
    logic [1:0] r;
    case (f3)
      3'b000:  r = {1'b1, eq};
      3'b001:  r = {1'b1, ~eq};
      3'b100:  r = {1'b1, ls};
      3'b101:  r = {1'b1, ~ls};
      3'b110:  r = {1'b1, lu};
      3'b111:  r = {1'b1, ~lu};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Decode helpers shared by the next-state and output logic
  always_comb begin
    code_ok_s     = is_onehot(code) && !code[C_SYSTEM];
    br_s          = branch_eval(ir_r[14:12], EQ, LS, LU);
    timeout_hit_s = TO_EN && (cnt_r == CNT_LAST);
  end

  // Next-state, fault cause and latched branch decision
  always_comb begin
    state_s = state_r;
    cause_s = 2'b00;
    taken_s = taken_r;
    case (state_r)
      S_IDLE: state_s = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_s = S_EXEC;
        end else if (timeout_hit_s) begin
          state_s = S_TRAP;
          cause_s = CAUSE_TIMEOUT;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_EXEC: begin
        if (!code_ok_s) begin
          state_s = S_TRAP;
          cause_s = CAUSE_ILLEGAL;
        end else if (code[C_BRANCH]) begin
          if (br_s[1]) begin
            taken_s = br_s[0];
            state_s = S_WB;
          end else begin
            state_s = S_TRAP;
            cause_s = CAUSE_ILLEGAL;
          end
        end else begin
          taken_s = 1'b0;
          state_s = (code[C_LOAD] || code[C_STORE]) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_s = S_WB;
        end else if (timeout_hit_s) begin
          state_s = S_TRAP;
          cause_s = CAUSE_TIMEOUT;
        end else begin
          state_s = S_MEM;
        end
      end
      S_WB:    state_s = S_FETCH;
      S_TRAP:  state_s = S_TRAP;
      default: state_s = S_IDLE;
    endcase
  end

  // Wait counter: restarts on any state change and on a completed handshake
  always_comb begin
    cnt_s = {CNT_W{1'b0}};
    if (!TO_EN || mem_ready || (state_s != state_r)) begin
      cnt_s = {CNT_W{1'b0}};
    end else if ((state_r == S_FETCH) || (state_r == S_MEM)) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = {CNT_W{1'b0}};
    end
  end

  // State, instruction, fault and retire registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      ir_r      <= 32'd0;
      taken_r   <= 1'b0;
      trap_r    <= 1'b0;
      cause_r   <= 2'b00;
      retired_r <= {RET_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      taken_r <= taken_s;
      cnt_r   <= cnt_s;
      if ((state_r == S_FETCH) && mem_ready) begin
        ir_r <= mem_rdata;
      end
      // Cause is captured only on the entering transition so it stays sticky
      if ((state_s == S_TRAP) && (state_r != S_TRAP)) begin
        trap_r  <= 1'b1;
        cause_r <= cause_s;
      end
      if (state_r == S_WB) begin
        retired_r <= retired_r + RET_W'(1);
      end
    end
  end

  // Strobe and select decode
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    pc_alu_sel  = 1'b0;
    sub_sra     = 1'b0;
    pc_next_sel = 1'b0;
    pc_we       = 1'b0;
    rd_we       = 1'b0;
    case (state_r)
      S_FETCH: mem_req = 1'b1;
      S_EXEC: begin
        if (code_ok_s) begin
          pc_alu_sel = code[C_AUIPC];
          if (code[C_BRANCH]) begin
            sub_sra = 1'b1;
          end else if (code[C_OP]) begin
            sub_sra = ir_r[30];
          end else if (code[C_OP_IMM]) begin
            // Only SRAI/SRLI carry the shift-type bit in ir[30]
            sub_sra = ir_r[30] & (ir_r[14:12] == 3'b101);
          end else begin
            sub_sra = 1'b0;
          end
        end else begin
          pc_alu_sel = 1'b0;
          sub_sra    = 1'b0;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = code[C_STORE];
      end
      S_WB: begin
        pc_we       = 1'b1;
        pc_next_sel = code[C_JAL] | code[C_JALR] | (code[C_BRANCH] & taken_r);
        pc_alu_sel  = code[C_JAL] | code[C_BRANCH];
        rd_we       = (code[C_LUI] | code[C_AUIPC] | code[C_JAL] | code[C_JALR] |
                       code[C_LOAD] | code[C_OP_IMM] | code[C_OP]) &
                      (ir_r[11:7] != 5'd0);
      end
      S_IDLE:  mem_req = 1'b0;
      S_TRAP:  mem_req = 1'b0;
      default: mem_req = 1'b0;
    endcase
  end

  assign ir         = ir_r;
  assign trap       = trap_r;
  assign trap_cause = cause_r;
  assign retired    = retired_r;

endmodule
